// File: rtl/par_to_serial.sv
// Byte-to-bit serializer: shifts bytes out MSB-first at 8x the byte rate,
// sending COM alignment symbols after reset and COM fill on idle slots.
module par_to_serial #(
    parameter logic [7:0] COM_SYMBOL    = 8'hBC,
    parameter int         ALIGN_SYMBOLS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       in_ready,
    output logic       data_out,
    output logic       frame_start,
    output logic       is_data,
    output logic       active
);

    typedef enum logic {ALIGN, ACTIVE} state_t;

    localparam logic [7:0] ALIGN_LAST = 8'(ALIGN_SYMBOLS - 1);

    state_t     state_q,     state_d;
    logic [7:0] shift_q,     shift_d;
    logic [2:0] bit_cnt_q,   bit_cnt_d;
    logic [7:0] align_cnt_q, align_cnt_d;
    logic       is_data_q,   is_data_d;
    logic       boundary;

    assign boundary    = (bit_cnt_q == 3'd7);
    assign in_ready    = boundary && ((state_q == ACTIVE) || (align_cnt_q == ALIGN_LAST));
    assign data_out    = shift_q[7];
    assign frame_start = (bit_cnt_q == 3'd0);
    assign is_data     = is_data_q;
    assign active      = (state_q == ACTIVE);

    always_comb begin
        state_d     = state_q;
        shift_d     = {shift_q[6:0], 1'b0};
        bit_cnt_d   = bit_cnt_q + 3'd1;
        align_cnt_d = align_cnt_q;
        is_data_d   = is_data_q;

        if (boundary) begin
            if (state_q == ALIGN && align_cnt_q < ALIGN_LAST) begin
                align_cnt_d = align_cnt_q + 8'd1;
                shift_d     = COM_SYMBOL;
                is_data_d   = 1'b0;
            end else begin
                // Last alignment slot loads exactly like an ACTIVE slot.
                state_d = ACTIVE;
                if (valid_in) begin
                    shift_d   = data_in;
                    is_data_d = 1'b1;
                end else begin
                    shift_d   = COM_SYMBOL;
                    is_data_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ALIGN;
            shift_q     <= COM_SYMBOL;
            bit_cnt_q   <= 3'd0;
            align_cnt_q <= 8'd0;
            is_data_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            align_cnt_q <= align_cnt_d;
            is_data_q   <= is_data_d;
        end
    end

endmodule

// File: tb/tb_par_to_serial.sv
// Bench for par_to_serial: two instances (ALIGN_SYMBOLS=4 and 1) checked every
// cycle against a symbol-slot model built from the recorded input stream.
module tb_par_to_serial;

    localparam logic [7:0] COM = 8'hBC;
    localparam int NHIST = 512;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;

    logic a_rdy, a_dout, a_fs, a_isd, a_act;
    logic b_rdy, b_dout, b_fs, b_isd, b_act;

    int total = 0;
    int bad   = 0;

    logic [7:0] d_hist [NHIST];
    logic       v_hist [NHIST];

    always #5 clk = ~clk;

    par_to_serial #(.COM_SYMBOL(8'hBC), .ALIGN_SYMBOLS(4)) u_a4 (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .in_ready(a_rdy), .data_out(a_dout), .frame_start(a_fs),
        .is_data(a_isd), .active(a_act)
    );

    par_to_serial #(.COM_SYMBOL(8'hBC), .ALIGN_SYMBOLS(1)) u_a1 (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .in_ready(b_rdy), .data_out(b_dout), .frame_start(b_fs),
        .is_data(b_isd), .active(b_act)
    );

    task automatic chk(input string tag, input int cyc, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Slot k carries COM during alignment, else whatever was offered at the
    // last cycle of the previous slot (COM if nothing valid was offered).
    function automatic logic [8:0] exp_slot(input int a, input int k);
        int p;
        if (k < a) return {1'b0, COM};
        p = 8 * k - 1;
        if (v_hist[p]) return {1'b1, d_hist[p]};
        return {1'b0, COM};
    endfunction

    task automatic chk_dut(input string nm, input int a, input int c,
                           input logic dout, input logic fs, input logic isd,
                           input logic act, input logic rdy);
        logic [8:0] e;
        e = exp_slot(a, c / 8);
        chk({nm, ".data_out"},    c, {7'd0, dout}, {7'd0, e[7 - (c % 8)]});
        chk({nm, ".frame_start"}, c, {7'd0, fs},   {7'd0, (c % 8) == 0});
        chk({nm, ".is_data"},     c, {7'd0, isd},  {7'd0, e[8]});
        chk({nm, ".active"},      c, {7'd0, act},  {7'd0, c >= 8 * a});
        chk({nm, ".in_ready"},    c, {7'd0, rdy},  {7'd0, ((c % 8) == 7) && (c >= 8 * a - 1)});
    endtask

    task automatic fill_random();
        for (int i = 0; i < NHIST; i++) begin
            d_hist[i] = 8'($urandom);
            v_hist[i] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic put(input int c, input logic [7:0] d, input logic v);
        d_hist[c] = d;
        v_hist[c] = v;
    endtask

    // Called with reset just released, i.e. inside cycle 0.
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            chk_dut("a4", 4, c, a_dout, a_fs, a_isd, a_act, a_rdy);
            chk_dut("a1", 1, c, b_dout, b_fs, b_isd, b_act, b_rdy);
            data_in  = d_hist[c];
            valid_in = v_hist[c];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // Run 1: alignment with random noise, then the directed byte sequence.
        fill_random();
        for (int c = 0; c < 31; c++) put(c, 8'($urandom), 1'b0);
        put(31, 8'hA5, 1'b1);
        put(39, 8'h00, 1'b1);
        put(47, 8'hFF, 1'b1);
        put(55, 8'h3C, 1'b1);
        put(63, 8'h12, 1'b1);
        put(71, 8'h99, 1'b0);
        put(79, 8'h34, 1'b1);
        for (int c = 81; c <= 86; c++) put(c, 8'h77, 1'b1);
        put(87, 8'h5A, 1'b1);
        do_reset();
        chk("reset.data_out", 0, {7'd0, a_dout}, 8'd1);
        chk("reset.in_ready", 0, {7'd0, a_rdy}, 8'd0);
        run(260);

        // Run 2: abort a data byte mid-symbol with an asynchronous reset.
        fill_random();
        put(31, 8'h4B, 1'b1);
        do_reset();
        run(35);
        #2;
        reset = 1'b1;
        #1;
        chk("async.data_out",    35, {7'd0, a_dout}, 8'd1);
        chk("async.active",      35, {7'd0, a_act},  8'd0);
        chk("async.is_data",     35, {7'd0, a_isd},  8'd0);
        chk("async.frame_start", 35, {7'd0, a_fs},   8'd1);
        chk("async.in_ready",    35, {7'd0, a_rdy},  8'd0);

        // Run 3: full realignment after release, random traffic.
        fill_random();
        do_reset();
        run(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
